// File: rtl/demux2_pkg.sv
// Shared types and constants for the demux2 slice.
// Counter types are consumed only when DEMUX2_CNT_EN is defined.
`ifndef DEMUX2_PKG_SV
`define DEMUX2_PKG_SV

package demux2_pkg;
    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;
endpackage

`endif

// File: rtl/demux2_out_slice.sv
// One-entry output register with full flag for a single demux channel.
// DEMUX2_CNT_EN adds a saturating count of completed output transfers.
`ifndef DEMUX2_OUT_SLICE_SV
`define DEMUX2_OUT_SLICE_SV

module demux2_out_slice
    import demux2_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [n-1:0] load_data,
    output logic         open,
    output logic [n-1:0] data,
    output logic         valid,
    input  logic         ready
`ifdef DEMUX2_CNT_EN
    ,
    output cnt_t         count
`endif
);

    logic full;
    logic xfer;

    assign open  = ~full | ready;
    assign xfer  = full & ready;
    assign valid = full;

    // A load takes priority over the drain so a simultaneous load and
    // transfer keeps the entry full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (xfer) begin
            full <= 1'b0;
        end
    end

`ifdef DEMUX2_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (xfer && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end
`endif

endmodule

`endif

// File: rtl/demux2_slice.sv
// Two-way valid/ready demultiplexer: in_select=1 routes to channel a, 0 to b.
// Build option DEMUX2_CNT_EN adds per-channel transfer counters a_count/b_count.
`ifndef DEMUX2_SLICE_SV
`define DEMUX2_SLICE_SV

module demux2_slice
    import demux2_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_select,
    output logic         in_ready,
    output logic [n-1:0] a_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [n-1:0] b_data,
    output logic         b_valid,
    input  logic         b_ready
`ifdef DEMUX2_CNT_EN
    ,
    output cnt_t         a_count,
    output cnt_t         b_count
`endif
);

    logic open_a;
    logic open_b;
    logic load_a;
    logic load_b;

    // in_ready deliberately ignores in_valid so the source can sample it freely.
    assign in_ready = in_select ? open_a : open_b;
    assign load_a   = in_valid &  in_select & open_a;
    assign load_b   = in_valid & ~in_select & open_b;

    demux2_out_slice #(.n(n)) u_slice_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_a),
        .load_data (in_data),
        .open      (open_a),
        .data      (a_data),
        .valid     (a_valid),
        .ready     (a_ready)
`ifdef DEMUX2_CNT_EN
        ,
        .count     (a_count)
`endif
    );

    demux2_out_slice #(.n(n)) u_slice_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_b),
        .load_data (in_data),
        .open      (open_b),
        .data      (b_data),
        .valid     (b_valid),
        .ready     (b_ready)
`ifdef DEMUX2_CNT_EN
        ,
        .count     (b_count)
`endif
    );

endmodule

`endif

// File: tb/tb_demux2_slice.sv
// Directed self-checking bench for demux2_slice; counter checks run when DEMUX2_CNT_EN is defined.
`timescale 1ns/1ps

module tb_demux2_slice;
    import demux2_pkg::*;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_select;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
`ifdef DEMUX2_CNT_EN
    cnt_t        a_count;
    cnt_t        b_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    demux2_slice #(.n(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_select (in_select),
        .in_ready  (in_ready),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready)
`ifdef DEMUX2_CNT_EN
        ,
        .a_count   (a_count),
        .b_count   (b_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int na;
        int nb;
        clk_en    = 1'b0;
        rst_n     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_select = 1'b1;
        a_ready   = 1'b0;
        b_ready   = 1'b0;

        // reset with clock stopped
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_a_data", 32'(a_data), 32'd0);
        chk("rst_b_data", 32'(b_data), 32'd0);
        chk("rst_in_ready_sel1", 32'(in_ready), 32'd1);
        in_select = 1'b0;
        #1;
        chk("rst_in_ready_sel0", 32'(in_ready), 32'd1);
`ifdef DEMUX2_CNT_EN
        chk("rst_a_count", 32'(a_count), 32'd0);
        chk("rst_b_count", 32'(b_count), 32'd0);
`endif
        #3 rst_n = 1'b1;
        clk_en = 1'b1;
        tick();

        // single route to a
        in_data = 16'hBEEF; in_select = 1'b1; in_valid = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_a_valid", 32'(a_valid), 32'd1);
        chk("single_a_data", 32'(a_data), 32'hBEEF);
        chk("single_b_valid", 32'(b_valid), 32'd0);
        tick();
        chk("single_a_valid_drop", 32'(a_valid), 32'd0);
        chk("single_b_valid_still", 32'(b_valid), 32'd0);

        // backpressure on a
        a_ready = 1'b0;
        in_data = 16'h0001; in_select = 1'b1; in_valid = 1'b1;
        #1 chk("bp_ready_empty", 32'(in_ready), 32'd1);
        tick();
        in_data = 16'h0002;
        #1 chk("bp_ready_full", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("bp_hold_valid", 32'(a_valid), 32'd1);
        chk("bp_hold_data", 32'(a_data), 32'h0001);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        a_ready = 1'b1;
        #1 chk("bp_ready_open", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_valid", 32'(a_valid), 32'd1);
        chk("bp_second_data", 32'(a_data), 32'h0002);
        tick();
        chk("bp_drained", 32'(a_valid), 32'd0);

        // a stalled and full, b keeps flowing
        a_ready = 1'b0; b_ready = 1'b1;
        in_data = 16'h00AA; in_select = 1'b1; in_valid = 1'b1;
        tick();
        in_select = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_data = 16'(16'h0B00 + i);
            #1 chk("ind_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("ind_b_valid", 32'(b_valid), 32'd1);
            chk("ind_b_data", 32'(b_data), 32'(16'h0B00 + i));
            chk("ind_a_data", 32'(a_data), 32'h00AA);
            chk("ind_a_valid", 32'(a_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("ind_b_drained", 32'(b_valid), 32'd0);
        a_ready = 1'b1;
        tick();
        chk("ind_a_drained", 32'(a_valid), 32'd0);

        // streaming, alternating select, both readies high
        na = 0; nb = 0;
        a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_select = (i % 2 == 0);
            in_data   = 16'(16'h1000 + i);
            #1 chk("str_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i % 2 == 0) begin
                chk("str_a_valid", 32'(a_valid), 32'd1);
                chk("str_a_data", 32'(a_data), 32'(16'h1000 + i));
                chk("str_b_idle", 32'(b_valid), 32'd0);
            end else begin
                chk("str_b_valid", 32'(b_valid), 32'd1);
                chk("str_b_data", 32'(b_data), 32'(16'h1000 + i));
                chk("str_a_idle", 32'(a_valid), 32'd0);
            end
            if (a_valid) na++;
            if (b_valid) nb++;
        end
        in_valid = 1'b0;
        tick();
        chk("str_a_beats", 32'(na), 32'd50);
        chk("str_b_beats", 32'(nb), 32'd50);
        chk("str_end_a_idle", 32'(a_valid), 32'd0);
        chk("str_end_b_idle", 32'(b_valid), 32'd0);

`ifdef DEMUX2_CNT_EN
        chk("cnt_a_pre", 32'(a_count), 32'd54);
        chk("cnt_b_pre", 32'(b_count), 32'd53);
        in_select = 1'b1; in_valid = 1'b1; a_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt_a_sat", 32'(a_count), 32'hFFFF);
        repeat (10) @(posedge clk);
        #1;
        chk("cnt_a_hold", 32'(a_count), 32'hFFFF);
        chk("cnt_b_same", 32'(b_count), 32'd53);
        in_valid = 1'b0;
        tick();
        tick();
        chk("cnt_a_final", 32'(a_count), 32'hFFFF);
`endif

        // mid-operation reset with both channels full
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_select = 1'b1; in_data = 16'h0A0A;
        tick();
        in_select = 1'b0; in_data = 16'h0B0B;
        tick();
        in_valid = 1'b0;
        chk("mr_a_full", 32'(a_valid), 32'd1);
        chk("mr_b_full", 32'(b_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_a_valid_async", 32'(a_valid), 32'd0);
        chk("mr_b_valid_async", 32'(b_valid), 32'd0);
        chk("mr_a_data", 32'(a_data), 32'd0);
        chk("mr_b_data", 32'(b_data), 32'd0);
`ifdef DEMUX2_CNT_EN
        chk("mr_a_count", 32'(a_count), 32'd0);
        chk("mr_b_count", 32'(b_count), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        tick();
        chk("mr_post_a_valid", 32'(a_valid), 32'd0);
        chk("mr_post_b_valid", 32'(b_valid), 32'd0);
        tick();
        chk("mr_post2_a_valid", 32'(a_valid), 32'd0);
        chk("mr_post2_b_valid", 32'(b_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux2_slice.md
DEMUX2_SLICE -- requirements
Module: demux2_slice

Interface
REQ-001 The block SHALL have parameter n, default 16, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_data, input, n, the source data word.
REQ-005 The block SHALL have port in_valid, input, 1, the source beat-present flag.
REQ-006 The block SHALL have port in_select, input, 1, the route: 1 = channel a, 0 = channel b (same polarity as mux2).
REQ-007 The block SHALL have port in_ready, output, 1, asserted when the block accepts a beat this cycle.
REQ-008 The block SHALL have ports a_data (output, n), a_valid (output, 1) and a_ready (input, 1), forming the channel-a sink handshake.
REQ-009 The block SHALL have ports b_data (output, n), b_valid (output, 1) and b_ready (input, 1), forming the channel-b sink handshake.
REQ-010 Under DEMUX2_CNT_EN only, the block SHALL have ports a_count and b_count, output, 16 bits each, the completed-transfer counts.

Function
REQ-011 Each channel SHALL hold a one-entry output register: a data word plus a full flag, which drives x_valid.
REQ-012 A channel SHALL be open when its full flag is 0 or its x_ready is 1 in the same cycle.
REQ-013 in_ready SHALL equal open(a) when in_select=1, and open(b) when in_select=0; it is combinational and independent of in_valid.
REQ-014 An input beat SHALL be accepted only when in_valid and in_ready are both 1 on the same clock edge.
REQ-015 An accepted beat SHALL load in_data into the selected channel register and set its full flag; x_valid rises the next cycle (latency 1).
REQ-016 An output transfer SHALL occur when x_valid and x_ready are both 1 on the same clock edge; without a simultaneous load, the full flag clears.
REQ-017 A simultaneous load and transfer on one channel SHALL keep full=1 with the new data, sustaining 1 beat/cycle.
REQ-018 The non-selected channel SHALL be unaffected by input activity and SHALL drain independently.
REQ-019 While x_valid=1 and x_ready=0, x_data and x_valid SHALL be held stable.
REQ-020 The source SHALL hold in_data and in_select stable while in_valid=1 and in_ready=0; the block has no protection against violations.
REQ-021 The block SHALL never drop or duplicate a beat; beat order within each channel is preserved.

Reset
REQ-022 While rst_n=0, the block SHALL force a_valid=0, b_valid=0, a_data=0, b_data=0 and both counters to 0, regardless of clk.
REQ-023 On reset assertion mid-operation, any held beats SHALL be discarded.
REQ-024 in_ready SHALL follow REQ-013 during reset, so it reads 1 because both channels are empty.

Configuration
REQ-025 With macro DEMUX2_CNT_EN defined, each channel SHALL count output transfers in a 16-bit counter that saturates at 16'hFFFF and never wraps.
REQ-026 With DEMUX2_CNT_EN undefined, the counters and the a_count and b_count ports SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package demux2_pkg SHALL hold localparam CNT_W=16, CNT_MAX='1 and typedef cnt_t (logic [CNT_W-1:0]).
REQ-028 The single-entry register and its full flag SHALL be sub-module demux2_out_slice, parameterized by n and instantiated once per channel.
REQ-029 The file SHALL use an include guard, matching catalog practice.

Verification
REQ-030 Reset check: drive rst_n=0 while clk is stopped -> a_valid=0, b_valid=0, in_ready=1, counters=0 immediately.
REQ-031 Single route: in_data=16'hBEEF, in_select=1, in_valid for 1 cycle, a_ready=1 -> a_valid=1 with a_data=16'hBEEF for exactly 1 cycle, b_valid stays 0.
REQ-032 Backpressure: a_ready=0, send 16'h0001 then 16'h0002 to a -> in_ready=0 after the first beat, a_data holds 16'h0001; raise a_ready -> 16'h0001 then 16'h0002 delivered in order.
REQ-033 Independent channels: a stalled and full, in_select=0 -> beats to b still accepted at 1/cycle, a untouched.
REQ-034 Streaming: 100 beats alternating select with both readies=1 -> in_ready held at 1 throughout, 50 beats delivered per channel, no gaps after the first.
REQ-035 Counters (DEMUX2_CNT_EN): preload stress with 70000 transfers on a -> a_count=16'hFFFF and holds; b_count equals b transfers.
REQ-036 Mid-operation reset: pulse rst_n low while both channels are full -> both valids drop asynchronously, and no stale beat appears after release.
